// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding
// and the sizing function for the shared cycle counter.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_e;

  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit over the largest terminal count keeps every compare wrap-free.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchroniser for a single level signal, cleared to 0 by a
// synchronous reset. Also usable by the domain-side reset receivers.
module pll_reset_sequencer_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer on the free-running reference clock: pulses the PLL
// reset, qualifies lock, then releases per-domain resets one at a time.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned RELEASE_GAP    = 8,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fail,
  output logic [RETRY_W-1:0]     retry_cnt
);

  localparam int unsigned CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_STABLE),
                                         max2(LOCK_TIMEOUT, RELEASE_GAP));
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0]   PRC_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   LS_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q;
  logic                   fail_q;
  logic                   lock_s;

  pll_reset_sequencer_sync2 u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == ST_PLL_RST);
      domain_rst_q <= domain_rst_d;
      ready_q      <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  // Every branch that changes state (or restarts PLL_RST) clears cnt; the
  // default increment only runs while a state is still counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_PLL_RST: begin
        if (soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == PRC_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (soft_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
          state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (soft_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LS_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      ST_RELEASE: begin
        if (!lock_s || soft_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s || soft_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Bit gi is released once the release index has reached it; bit 0 opens on RELEASE entry.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
    if (gi == 0) begin : g_first
      assign domain_rst_d[gi] = !((state_d == ST_RUN) || (state_d == ST_RELEASE));
    end else begin : g_rest
      assign domain_rst_d[gi] = !((state_d == ST_RUN) ||
                                  ((state_d == ST_RELEASE) && (idx_d >= IDX_W'(gi))));
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: randomized lock timing and restart requests, with
// expected event cycles derived arithmetically from the sequencing rules.
module tb_pll_reset_sequencer;

  localparam int N   = 4;
  localparam int PRC = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
  localparam int GAP = 2;
  localparam int MR  = 3;

  logic         refclk     = 1'b0;
  logic         rst        = 1'b1;
  logic         pll_locked = 1'b0;
  logic         soft_req   = 1'b0;
  logic         pll_rst;
  logic [N-1:0] domain_rst;
  logic         ready;
  logic         fail;
  logic [3:0]   retry_cnt;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t_fall;
  int t_rdy;
  int t_clr[N];

  pll_reset_sequencer #(
    .NUM_DOMAINS    (N),
    .PLL_RST_CYCLES (PRC),
    .LOCK_STABLE    (LS),
    .LOCK_TIMEOUT   (TO),
    .RELEASE_GAP    (GAP),
    .MAX_RETRIES    (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_req   (soft_req),
    .pll_rst    (pll_rst),
    .domain_rst (domain_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // Model: synced lock is first seen by the FSM 3 edges after the input
  // changes; STABLE begins one cycle after WAIT_LOCK entry at the earliest.
  function automatic int stable_at(input int tf, input int nl);
    return (tf + 1 > nl + 3) ? tf + 1 : nl + 3;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic release_reset(output int c0);
    @(negedge refclk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    c0  = cyc;
  endtask

  // Records the pll_rst fall, per-bit release and ready rise cycles; raises
  // pll_locked when the cycle counter reaches raise_at.
  task automatic monitor(input int raise_at, input int budget);
    logic prev;
    prev   = pll_rst;
    t_fall = -1;
    t_rdy  = -1;
    for (int i = 0; i < N; i++) t_clr[i] = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge refclk);
      if (prev && !pll_rst && t_fall < 0) t_fall = cyc;
      prev = pll_rst;
      for (int i = 0; i < N; i++)
        if (t_clr[i] < 0 && !domain_rst[i]) t_clr[i] = cyc;
      if (ready) begin
        t_rdy = cyc;
        break;
      end
      if (cyc == raise_at) pll_locked = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge refclk);
    pll_locked = 1'($urandom_range(0, 1));
    soft_req   = 1'($urandom_range(0, 1));
    rst        = 1'b1;
    tick(2);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %0b expected 1", pll_rst); end
    checks++; if (domain_rst !== {N{1'b1}}) begin errors++; $display("FAIL reset_domain_rst: got %h expected %h", domain_rst, {N{1'b1}}); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0b expected 0", fail); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    soft_req = 1'b0;
    $display("test_reset: reset values sampled at cycle %0d", cyc);
  endtask

  task automatic test_clean_bringup();
    int c0, tf_exp, nl, base;
    pll_locked = 1'b0;
    release_reset(c0);
    tf_exp = c0 + PRC;
    nl     = tf_exp + 10;
    monitor(nl, 120);
    base = stable_at(tf_exp, nl);
    checks++; if (t_fall !== tf_exp) begin errors++; $display("FAIL clean_pll_rst_fall: got %0d expected %0d", t_fall, tf_exp); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (t_clr[i] !== base + LS + i * GAP) begin
        errors++; $display("FAIL clean_bit%0d_release: got %0d expected %0d", i, t_clr[i], base + LS + i * GAP);
      end
    end
    checks++; if (t_rdy !== base + LS + (N - 1) * GAP + 1) begin errors++; $display("FAIL clean_ready: got %0d expected %0d", t_rdy, base + LS + (N - 1) * GAP + 1); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL clean_retry_cnt: got %0d expected 0", retry_cnt); end
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL clean_pll_rst_low: got %0b expected 0", pll_rst); end
    $display("test_clean_bringup: lock at %0d ready at %0d", nl, t_rdy);
  endtask

  task automatic test_lock_loss_in_run();
    int n, k, tf_exp, nl;
    tick($urandom_range(1, 5));
    pll_locked = 1'b0;
    n = cyc;
    tick(3);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready: got %0b expected 0", ready); end
    checks++; if (domain_rst !== {N{1'b1}}) begin errors++; $display("FAIL loss_domain_rst: got %h expected %h", domain_rst, {N{1'b1}}); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst: got %0b expected 1", pll_rst); end
    k      = $urandom_range(1, 20);
    tf_exp = n + 3 + PRC;
    nl     = n + 3 + k;
    monitor(nl, 150);
    checks++; if (t_fall !== tf_exp) begin errors++; $display("FAIL loss_pll_rst_fall: got %0d expected %0d", t_fall, tf_exp); end
    checks++; if (t_rdy !== stable_at(tf_exp, nl) + LS + (N - 1) * GAP + 1) begin
      errors++; $display("FAIL loss_resequence_ready: got %0d expected %0d", t_rdy, stable_at(tf_exp, nl) + LS + (N - 1) * GAP + 1);
    end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_retry_cnt: got %0d expected 0", retry_cnt); end
    $display("test_lock_loss_in_run: drop at %0d relock at %0d ready at %0d", n, nl, t_rdy);
  endtask

  task automatic test_soft_mid_release();
    int ns, tf_exp, t1;
    logic prev;
    soft_req = 1'b1;
    ns = cyc;
    tick(1);
    soft_req = 1'b0;
    checks++; if (domain_rst !== {N{1'b1}} || ready !== 1'b0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL soft_run_restart: got dom=%h rdy=%0b prst=%0b expected dom=%h rdy=0 prst=1", domain_rst, ready, pll_rst, {N{1'b1}});
    end
    tf_exp = ns + 1 + PRC;
    t_fall = -1;
    t1     = -1;
    prev   = pll_rst;
    for (int k = 0; k < 80; k++) begin
      @(negedge refclk);
      if (prev && !pll_rst && t_fall < 0) t_fall = cyc;
      prev = pll_rst;
      if (!domain_rst[1]) begin
        t1 = cyc;
        break;
      end
    end
    checks++; if (t_fall !== tf_exp) begin errors++; $display("FAIL soft_pll_rst_fall: got %0d expected %0d", t_fall, tf_exp); end
    checks++; if (t1 !== tf_exp + 1 + LS + GAP) begin errors++; $display("FAIL soft_bit1_release: got %0d expected %0d", t1, tf_exp + 1 + LS + GAP); end
    checks++; if (domain_rst !== 4'b1100) begin errors++; $display("FAIL soft_partial_release: got %h expected c", domain_rst); end
    soft_req = 1'b1;
    ns = cyc;
    tick(1);
    soft_req = 1'b0;
    checks++; if (domain_rst !== {N{1'b1}} || ready !== 1'b0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL soft_release_restart: got dom=%h rdy=%0b prst=%0b expected dom=%h rdy=0 prst=1", domain_rst, ready, pll_rst, {N{1'b1}});
    end
    tf_exp = ns + 1 + PRC;
    monitor(-1, 100);
    checks++; if (t_fall !== tf_exp) begin errors++; $display("FAIL soft_repulse_fall: got %0d expected %0d", t_fall, tf_exp); end
    checks++; if (t_rdy !== tf_exp + 1 + LS + (N - 1) * GAP + 1) begin
      errors++; $display("FAIL soft_resequence_ready: got %0d expected %0d", t_rdy, tf_exp + 1 + LS + (N - 1) * GAP + 1);
    end
    $display("test_soft_mid_release: bit1 at %0d ready at %0d", t1, t_rdy);
  endtask

  task automatic test_back_to_back();
    int ns, tf_exp, nl, exp_rdy;
    for (int it = 0; it < 4; it++) begin
      tick($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        soft_req = 1'b1;
        ns = cyc;
        tick(1);
        soft_req = 1'b0;
        tf_exp  = ns + 1 + PRC;
        exp_rdy = tf_exp + 1 + LS + (N - 1) * GAP + 1;
        monitor(-1, 100);
      end else begin
        pll_locked = 1'b0;
        ns = cyc;
        tick(3);
        tf_exp  = ns + 3 + PRC;
        nl      = ns + 3 + $urandom_range(1, 20);
        exp_rdy = stable_at(tf_exp, nl) + LS + (N - 1) * GAP + 1;
        monitor(nl, 150);
      end
      checks++; if (t_fall !== tf_exp) begin errors++; $display("FAIL b2b_pll_rst_fall[%0d]: got %0d expected %0d", it, t_fall, tf_exp); end
      checks++; if (t_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %0d expected %0d", it, t_rdy, exp_rdy); end
      $display("test_back_to_back[%0d]: restart at %0d ready at %0d", it, ns, t_rdy);
    end
  endtask

  task automatic test_glitch();
    int c0, n1, n2;
    pll_locked = 1'b0;
    release_reset(c0);
    tick(PRC + $urandom_range(0, 10));
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL glitch_pll_rst_low: got %0b expected 0", pll_rst); end
    pll_locked = 1'b1;
    n1 = cyc;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    n2 = cyc;
    monitor(-1, 80);
    checks++; if (t_clr[0] !== n2 + 3 + LS) begin errors++; $display("FAIL glitch_bit0_release: got %0d expected %0d", t_clr[0], n2 + 3 + LS); end
    checks++; if (!(t_clr[0] > n1 + 3 + LS)) begin errors++; $display("FAIL glitch_early_release: got %0d expected after %0d", t_clr[0], n1 + 3 + LS); end
    checks++; if (t_rdy !== n2 + 3 + LS + (N - 1) * GAP + 1) begin errors++; $display("FAIL glitch_ready: got %0d expected %0d", t_rdy, n2 + 3 + LS + (N - 1) * GAP + 1); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL glitch_retry_cnt: got %0d expected 0", retry_cnt); end
    $display("test_glitch: first lock %0d relock %0d release %0d", n1, n2, t_clr[0]);
  endtask

  task automatic test_never_locks();
    int c0, t_fail, nrise;
    int t_r[4];
    int rise[4];
    logic prev_rst;
    logic [3:0] prev_r;
    pll_locked = 1'b0;
    release_reset(c0);
    for (int i = 0; i < 4; i++) begin
      t_r[i]  = -1;
      rise[i] = -1;
    end
    t_fail   = -1;
    nrise    = 0;
    prev_rst = pll_rst;
    prev_r   = retry_cnt;
    for (int k = 0; k < MR * (PRC + TO) + 20; k++) begin
      @(negedge refclk);
      if (retry_cnt != prev_r && retry_cnt <= 4'd3) t_r[retry_cnt] = cyc;
      if (!prev_rst && pll_rst) begin
        if (nrise < 4) rise[nrise] = cyc;
        nrise++;
      end
      if (fail && t_fail < 0) t_fail = cyc;
      prev_rst = pll_rst;
      prev_r   = retry_cnt;
    end
    for (int k = 1; k <= MR; k++) begin
      checks++;
      if (t_r[k] !== c0 + k * (PRC + TO)) begin
        errors++; $display("FAIL never_retry%0d_time: got %0d expected %0d", k, t_r[k], c0 + k * (PRC + TO));
      end
    end
    checks++; if (nrise !== MR - 1) begin errors++; $display("FAIL never_repulse_count: got %0d expected %0d", nrise, MR - 1); end
    checks++; if (rise[1] - rise[0] !== PRC + TO) begin errors++; $display("FAIL never_pulse_spacing: got %0d expected %0d", rise[1] - rise[0], PRC + TO); end
    checks++; if (t_fail !== c0 + MR * (PRC + TO)) begin errors++; $display("FAIL never_fail_time: got %0d expected %0d", t_fail, c0 + MR * (PRC + TO)); end
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b0 || domain_rst !== 4'hF || ready !== 1'b0 || retry_cnt !== 4'd3) begin
      errors++; $display("FAIL never_fail_outputs: got fail=%0b prst=%0b dom=%h rdy=%0b retry=%0d expected 1 0 f 0 3", fail, pll_rst, domain_rst, ready, retry_cnt);
    end
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(3);
    checks++; if (fail !== 1'b1 || pll_rst !== 1'b0) begin errors++; $display("FAIL never_soft_ignored: got fail=%0b prst=%0b expected fail=1 prst=0", fail, pll_rst); end
    rst = 1'b1;
    tick(1);
    checks++; if (fail !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL never_rst_clears: got fail=%0b retry=%0d prst=%0b expected 0 0 1", fail, retry_cnt, pll_rst);
    end
    $display("test_never_locks: fail raised at %0d", t_fail);
  endtask

  task automatic test_rst_in_run();
    int c0;
    pll_locked = 1'b0;
    release_reset(c0);
    monitor(c0 + $urandom_range(0, 8), 120);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstrun_reached_run: got %0b expected 1", ready); end
    tick($urandom_range(0, 3));
    rst = 1'b1;
    tick(1);
    checks++; if (pll_rst !== 1'b1 || domain_rst !== {N{1'b1}} || ready !== 1'b0 || fail !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL rstrun_outputs: got prst=%0b dom=%h rdy=%0b fail=%0b retry=%0d expected 1 f 0 0 0", pll_rst, domain_rst, ready, fail, retry_cnt);
    end
    rst = 1'b0;
    $display("test_rst_in_run: reset applied at cycle %0d", cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_bringup();
    test_lock_loss_in_run();
    test_soft_mid_release();
    test_back_to_back();
    test_glitch();
    test_never_locks();
    test_rst_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
